// File: rtl/filter_scan_ctrl.sv
// Raster-scan sequencer for a fixed-latency pixel filter: issues WIDTH x HEIGHT
// pixels under source/sink flow control, tags the output stream, signals frame end.
module filter_scan_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    input  logic        SRC_VALID,
    input  logic        SINK_AFULL,
    output logic        READY,
    output logic [11:0] POSX,
    output logic [11:0] POSY,
    input  logic        FILT_WREN,
    output logic        OUT_SOF,
    output logic        OUT_EOL,
    output logic        OUT_EOF,
    output logic        ERR
);
    localparam logic [11:0] XMAX = 12'(WIDTH - 1);
    localparam logic [11:0] YMAX = 12'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] ix, iy, ox, oy;
    logic [7:0]  inflight, inflight_nxt;
    logic        active, issue, wren, last_issue, err_nxt;

    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign READY      = (state == S_RUN) && SRC_VALID && !SINK_AFULL;
    assign issue      = READY;
    // Filter writes outside a frame are ignored entirely.
    assign wren       = active && FILT_WREN;
    assign last_issue = issue && (ix == XMAX) && (iy == YMAX);

    assign BUSY    = active;
    assign DONE    = (state == S_DONE);
    assign POSX    = ix;
    assign POSY    = iy;
    assign OUT_SOF = wren && (ox == 12'd0) && (oy == 12'd0);
    assign OUT_EOL = wren && (ox == XMAX);
    assign OUT_EOF = OUT_EOL && (oy == YMAX);

    always_comb begin
        inflight_nxt = inflight;
        err_nxt      = ERR;
        if (issue && !wren) begin
            if (inflight == 8'hff) err_nxt = 1'b1;
            else inflight_nxt = inflight + 8'd1;
        end else if (wren && !issue) begin
            if (inflight == 8'd0) err_nxt = 1'b1;
            else inflight_nxt = inflight - 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_RUN;
            S_RUN:   if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (inflight_nxt == 8'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            ix       <= 12'd0;
            iy       <= 12'd0;
            ox       <= 12'd0;
            oy       <= 12'd0;
            inflight <= 8'd0;
            ERR      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (START) begin
                    ix       <= 12'd0;
                    iy       <= 12'd0;
                    ox       <= 12'd0;
                    oy       <= 12'd0;
                    inflight <= 8'd0;
                    ERR      <= 1'b0;
                end
            end else begin
                inflight <= inflight_nxt;
                ERR      <= err_nxt;
                if (issue) begin
                    if (ix == XMAX) begin
                        ix <= 12'd0;
                        iy <= iy + 12'd1;
                    end else begin
                        ix <= ix + 12'd1;
                    end
                end
                if (wren) begin
                    if (ox == XMAX) begin
                        ox <= 12'd0;
                        oy <= oy + 12'd1;
                    end else begin
                        ox <= ox + 12'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Bench for filter_scan_ctrl: a 4x2 and a 1x1 instance, a delay-line filter model,
// and a frame-level reference model counting issued/written pixels.
module tb_filter_scan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, src_valid = 1'b0, sink_afull = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, mwren_a = 1'b0, mwren_b = 1'b0;
    logic busy_a, done_a, ready_a, sof_a, eol_a, eof_a, err_a, wren_a;
    logic busy_b, done_b, ready_b, sof_b, eol_b, eof_b, err_b, wren_b;
    logic [11:0] px_a, py_a, px_b, py_b;
    logic [15:0] hist_a = '0, hist_b = '0;
    int   lat = 1;
    logic model_on = 1'b0;
    logic sel = 1'b0;

    filter_scan_ctrl #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .CLK(clk), .RST(rst_n), .START(start_a), .BUSY(busy_a), .DONE(done_a),
        .SRC_VALID(src_valid), .SINK_AFULL(sink_afull), .READY(ready_a),
        .POSX(px_a), .POSY(py_a), .FILT_WREN(wren_a), .OUT_SOF(sof_a),
        .OUT_EOL(eol_a), .OUT_EOF(eof_a), .ERR(err_a));

    filter_scan_ctrl #(.WIDTH(1), .HEIGHT(1)) dut_b (
        .CLK(clk), .RST(rst_n), .START(start_b), .BUSY(busy_b), .DONE(done_b),
        .SRC_VALID(src_valid), .SINK_AFULL(sink_afull), .READY(ready_b),
        .POSX(px_b), .POSY(py_b), .FILT_WREN(wren_b), .OUT_SOF(sof_b),
        .OUT_EOL(eol_b), .OUT_EOF(eof_b), .ERR(err_b));

    // Filter model: each issued pixel comes back 'lat' cycles later.
    always @(posedge clk) begin
        hist_a <= {hist_a[14:0], ready_a === 1'b1};
        hist_b <= {hist_b[14:0], ready_b === 1'b1};
    end
    assign wren_a = mwren_a | (model_on & hist_a[lat-1]);
    assign wren_b = mwren_b | (model_on & hist_b[lat-1]);

    logic o_ready, o_busy, o_done, o_err, o_sof, o_eol, o_eof, o_wren;
    logic [11:0] o_x, o_y;
    always_comb begin
        o_ready = sel ? ready_b : ready_a;
        o_busy  = sel ? busy_b  : busy_a;
        o_done  = sel ? done_b  : done_a;
        o_err   = sel ? err_b   : err_a;
        o_sof   = sel ? sof_b   : sof_a;
        o_eol   = sel ? eol_b   : eol_a;
        o_eof   = sel ? eof_b   : eof_a;
        o_wren  = sel ? wren_b  : wren_a;
        o_x     = sel ? px_b    : px_a;
        o_y     = sel ? py_b    : py_a;
    end

    // Reference model: frame progress as counts of issued and written pixels.
    int W = 4, H = 2;
    bit m_busy, m_done, m_err, pend;
    int n_iss, n_out, m_infl;
    bit c_st, c_rn, c_wren, e_run, e_ready, e_sof, e_eol, e_eof;
    logic [11:0] e_x, e_y;
    int checks = 0, errs = 0;

    task automatic model_update();
        bit all_in;
        if (!c_rn) begin
            m_busy = 0; m_done = 0; m_err = 0; n_iss = 0; n_out = 0; m_infl = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            all_in = (n_iss == W * H);
            if (e_ready && !c_wren) begin
                if (m_infl == 255) m_err = 1; else m_infl++;
            end else if (c_wren && !e_ready) begin
                if (m_infl == 0) m_err = 1; else m_infl--;
            end
            if (e_ready) n_iss++;
            if (c_wren) n_out++;
            if (all_in && m_infl == 0) begin m_busy = 0; m_done = 1; end
        end else if (c_st) begin
            m_busy = 1; m_err = 0; n_iss = 0; n_out = 0; m_infl = 0;
        end
    endtask

    task automatic drive(input bit st, input bit sv, input bit af, input bit rn, input bit mw);
        if (pend) model_update();
        @(negedge clk);
        rst_n = rn; src_valid = sv; sink_afull = af;
        start_a = st && !sel; start_b = st && sel;
        mwren_a = mw && !sel; mwren_b = mw && sel;
        #1;
        c_st = st; c_rn = rn;
        c_wren  = m_busy && (o_wren === 1'b1);
        e_run   = m_busy && (n_iss < W * H);
        e_ready = e_run && sv && !af;
        e_x     = 12'(n_iss % W);
        e_y     = 12'(n_iss / W);
        e_sof   = c_wren && (n_out == 0);
        e_eol   = c_wren && ((n_out % W) == W - 1);
        e_eof   = c_wren && (n_out == W * H - 1);
        pend = 1;
    endtask

    task automatic settle();
        int n = 0;
        while ((m_busy || m_done) && n < 300) begin drive(0, 1, 0, 1, 0); n++; end
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errs++; $display("FAIL settle_idle busy=%b done=%b exp 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        checks++;
        if ({o_busy, o_done, o_err, o_ready} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags busy/done/err/ready=%b%b%b%b exp 0000", o_busy, o_done, o_err, o_ready);
        end
        checks++;
        if (o_x !== 12'd0 || o_y !== 12'd0) begin
            errs++; $display("FAIL reset_pos got (%0d,%0d) exp (0,0)", o_x, o_y);
        end
        model_on = 1;
    endtask

    task automatic test_basic();
        int nrdy = 0, ndone = 0, neol = 0, neof = 0, fr = -1, lr = -1;
        for (int c = 0; c < 20; c++) begin
            drive(c == 0, 1, 0, 1, 0);
            checks++; if (o_ready !== e_ready) begin errs++; $display("FAIL basic_ready c=%0d got %b exp %b", c, o_ready, e_ready); end
            checks++; if ({o_busy, o_done, o_err} !== {m_busy, m_done, m_err}) begin errs++; $display("FAIL basic_flags c=%0d got %b%b%b exp %b%b%b", c, o_busy, o_done, o_err, m_busy, m_done, m_err); end
            if (e_run) begin checks++; if ({o_x, o_y} !== {e_x, e_y}) begin errs++; $display("FAIL basic_pos c=%0d got (%0d,%0d) exp (%0d,%0d)", c, o_x, o_y, e_x, e_y); end end
            checks++; if ({o_sof, o_eol, o_eof} !== {e_sof, e_eol, e_eof}) begin errs++; $display("FAIL basic_tags c=%0d got %b%b%b exp %b%b%b", c, o_sof, o_eol, o_eof, e_sof, e_eol, e_eof); end
            if (o_ready === 1'b1) begin nrdy++; if (fr < 0) fr = c; lr = c; end
            if (o_done === 1'b1) ndone++;
            if (o_eol === 1'b1) neol++;
            if (o_eof === 1'b1) neof++;
        end
        checks++; if (nrdy != 8 || lr - fr != 7) begin errs++; $display("FAIL basic_ready_run got %0d issues span %0d exp 8 span 7", nrdy, lr - fr); end
        checks++; if (ndone != 1 || neol != 2 || neof != 1) begin errs++; $display("FAIL basic_counts done/eol/eof=%0d/%0d/%0d exp 1/2/1", ndone, neol, neof); end
        settle();
    endtask

    task automatic test_backpressure();
        int nout = 0, ndone = 0;
        bit sv, af;
        for (int c = 0; c < 40; c++) begin
            sv = (c % 2) == 0;
            af = (c >= 4 && c < 7);
            drive(c == 0, sv, af, 1, 0);
            checks++; if (o_ready !== e_ready) begin errs++; $display("FAIL bp_ready c=%0d got %b exp %b", c, o_ready, e_ready); end
            if (o_ready === 1'b1 && (!sv || af)) begin errs++; $display("FAIL bp_blocked c=%0d ready=1 exp 0", c); end
            checks++; if ({o_busy, o_done} !== {m_busy, m_done}) begin errs++; $display("FAIL bp_flags c=%0d got %b%b exp %b%b", c, o_busy, o_done, m_busy, m_done); end
            if (e_run) begin checks++; if ({o_x, o_y} !== {e_x, e_y}) begin errs++; $display("FAIL bp_pos c=%0d got (%0d,%0d) exp (%0d,%0d)", c, o_x, o_y, e_x, e_y); end end
            checks++; if ({o_sof, o_eol, o_eof} !== {e_sof, e_eol, e_eof}) begin errs++; $display("FAIL bp_tags c=%0d got %b%b%b exp %b%b%b", c, o_sof, o_eol, o_eof, e_sof, e_eol, e_eof); end
            if (c_wren) nout++;
            if (o_done === 1'b1) ndone++;
        end
        checks++; if (nout != 8 || ndone != 1) begin errs++; $display("FAIL bp_counts outputs/done=%0d/%0d exp 8/1", nout, ndone); end
        settle();
    endtask

    task automatic test_latency4();
        int nw = 0, fw = -1, dc = -1;
        lat = 4;
        for (int c = 0; c < 24; c++) begin
            drive(c == 0, 1, 0, 1, 0);
            checks++; if ({o_ready, o_busy, o_done} !== {e_ready, m_busy, m_done}) begin errs++; $display("FAIL lat4_flags c=%0d got %b%b%b exp %b%b%b", c, o_ready, o_busy, o_done, e_ready, m_busy, m_done); end
            checks++; if ({o_sof, o_eol, o_eof} !== {e_sof, e_eol, e_eof}) begin errs++; $display("FAIL lat4_tags c=%0d got %b%b%b exp %b%b%b", c, o_sof, o_eol, o_eof, e_sof, e_eol, e_eof); end
            if (c_wren) begin nw++; if (nw == 8) fw = c; end
            if (o_done === 1'b1 && dc < 0) dc = c;
        end
        checks++; if (fw < 0 || dc != fw + 1) begin errs++; $display("FAIL lat4_done_timing done at %0d exp %0d", dc, fw + 1); end
        settle();
        lat = 1;
    endtask

    task automatic test_start_held();
        int ndone = 0, mframes = 0;
        bit sv, af;
        lat = int'($urandom_range(1, 5));
        for (int c = 0; c < 160; c++) begin
            sv = ($urandom % 4) != 0;
            af = ($urandom % 5) == 0;
            drive(1, sv, af, 1, 0);
            checks++; if ({o_ready, o_busy, o_done, o_err} !== {e_ready, m_busy, m_done, m_err}) begin errs++; $display("FAIL held_flags c=%0d got %b%b%b%b exp %b%b%b%b", c, o_ready, o_busy, o_done, o_err, e_ready, m_busy, m_done, m_err); end
            if (e_run) begin checks++; if ({o_x, o_y} !== {e_x, e_y}) begin errs++; $display("FAIL held_pos c=%0d got (%0d,%0d) exp (%0d,%0d)", c, o_x, o_y, e_x, e_y); end end
            checks++; if ({o_sof, o_eol, o_eof} !== {e_sof, e_eol, e_eof}) begin errs++; $display("FAIL held_tags c=%0d got %b%b%b exp %b%b%b", c, o_sof, o_eol, o_eof, e_sof, e_eol, e_eof); end
            if (o_done === 1'b1) ndone++;
            if (m_done) mframes++;
        end
        checks++; if (ndone != mframes || ndone < 2) begin errs++; $display("FAIL held_frames got %0d exp %0d (>=2)", ndone, mframes); end
        settle();
        lat = 1;
    endtask

    task automatic test_reset_mid();
        int nrdy = 0, n = 0, ndone = 0;
        lat = 3;
        drive(1, 1, 0, 1, 0);
        while (nrdy < 5 && n < 20) begin
            drive(0, 1, 0, 1, 0);
            if (o_ready === 1'b1) nrdy++;
            n++;
        end
        checks++; if (nrdy != 5) begin errs++; $display("FAIL rmid_issues got %0d exp 5", nrdy); end
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        checks++; if ({o_busy, o_done} !== 2'b00 || o_x !== 12'd0 || o_y !== 12'd0) begin errs++; $display("FAIL rmid_after busy=%b done=%b pos=(%0d,%0d) exp 0 0 (0,0)", o_busy, o_done, o_x, o_y); end
        for (int c = 0; c < 10; c++) begin
            drive(0, 1, 0, 1, 0);
            checks++; if ({o_err, o_done} !== 2'b00) begin errs++; $display("FAIL rmid_stray c=%0d err=%b done=%b exp 0 0", c, o_err, o_done); end
        end
        for (int c = 0; c < 24; c++) begin
            drive(c == 0, 1, 0, 1, 0);
            checks++; if ({o_ready, o_busy, o_done, o_err} !== {e_ready, m_busy, m_done, m_err}) begin errs++; $display("FAIL rmid_frame c=%0d got %b%b%b%b exp %b%b%b%b", c, o_ready, o_busy, o_done, o_err, e_ready, m_busy, m_done, m_err); end
            if (e_run) begin checks++; if ({o_x, o_y} !== {e_x, e_y}) begin errs++; $display("FAIL rmid_pos c=%0d got (%0d,%0d) exp (%0d,%0d)", c, o_x, o_y, e_x, e_y); end end
            if (o_done === 1'b1) ndone++;
        end
        checks++; if (ndone != 1) begin errs++; $display("FAIL rmid_done got %0d exp 1", ndone); end
        settle();
        lat = 1;
    endtask

    task automatic test_err();
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 1, 0, 1, 0);
        checks++; if (o_err !== 1'b1) begin errs++; $display("FAIL err_set got %b exp 1", o_err); end
        for (int c = 0; c < 16; c++) begin
            drive(0, 1, 0, 1, 0);
            checks++; if ({o_ready, o_busy, o_done, o_err} !== {e_ready, m_busy, m_done, m_err}) begin errs++; $display("FAIL err_frame c=%0d got %b%b%b%b exp %b%b%b%b", c, o_ready, o_busy, o_done, o_err, e_ready, m_busy, m_done, m_err); end
            checks++; if ({o_sof, o_eol, o_eof} !== {e_sof, e_eol, e_eof}) begin errs++; $display("FAIL err_tags c=%0d got %b%b%b exp %b%b%b", c, o_sof, o_eol, o_eof, e_sof, e_eol, e_eof); end
        end
        settle();
        checks++; if (o_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", o_err); end
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        checks++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin errs++; $display("FAIL err_clear err=%b busy=%b exp 0 1", o_err, o_busy); end
        settle();
    endtask

    task automatic test_tiny();
        int nrdy = 0, nw = 0, ndone = 0;
        sel = 1; W = 1; H = 1;
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, 1, 0, 1, 0);
            checks++; if ({o_ready, o_busy, o_done} !== {e_ready, m_busy, m_done}) begin errs++; $display("FAIL tiny_flags c=%0d got %b%b%b exp %b%b%b", c, o_ready, o_busy, o_done, e_ready, m_busy, m_done); end
            if (o_ready === 1'b1) begin
                nrdy++;
                checks++; if (o_x !== 12'd0 || o_y !== 12'd0) begin errs++; $display("FAIL tiny_pos got (%0d,%0d) exp (0,0)", o_x, o_y); end
            end
            if (c_wren) begin
                nw++;
                checks++; if ({o_sof, o_eol, o_eof} !== 3'b111) begin errs++; $display("FAIL tiny_tags got %b%b%b exp 111", o_sof, o_eol, o_eof); end
            end
            if (o_done === 1'b1) ndone++;
        end
        checks++; if (nrdy != 1 || nw != 1 || ndone != 1) begin errs++; $display("FAIL tiny_counts issues/outputs/done=%0d/%0d/%0d exp 1/1/1", nrdy, nw, ndone); end
        settle();
        sel = 0; W = 4; H = 2;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_latency4();
        test_start_held();
        test_reset_mid();
        test_err();
        test_tiny();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/filter_scan_ctrl.md
Name: filter_scan_ctrl

Overview:
- Frame-scan sequencer for a single-pixel, fixed-latency filter stage (grayscale and siblings), which has inputs POSX/POSY/READY and outputs RDEN=READY and WREN.
- On START it walks a WIDTH x HEIGHT raster and issues one pixel per cycle to the filter when the source has data and the sink has room.
- It tracks pixels in flight, tags the filter's output stream with SOF/EOL/EOF, and pulses DONE once the last output pixel has been written.

Parameters:
- WIDTH, 640, pixels per line (1..4095)
- HEIGHT, 480, lines per frame (1..4095)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-low (RST=0 resets on the next CLK edge)
- START  in  1  begin one frame; honoured only in IDLE
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  one-cycle pulse at end of frame
- SRC_VALID  in  1  input pixel available from source (source pops on READY)
- SINK_AFULL  in  1  sink cannot take more pixels; sink threshold covers filter latency
- READY  out  1  to filter READY and source pop
- POSX  out  12  x of pixel being issued
- POSY  out  12  y of pixel being issued
- FILT_WREN  in  1  filter WREN (output pixel valid)
- OUT_SOF  out  1  FILT_WREN for output pixel (0,0)
- OUT_EOL  out  1  FILT_WREN for output x=WIDTH-1
- OUT_EOF  out  1  FILT_WREN for output pixel (WIDTH-1,HEIGHT-1)
- ERR  out  1  sticky protocol error

Behaviour:
- Reset values: state=IDLE; BUSY, DONE, ERR = 0; POSX, POSY = 0; input counters (ix, iy) = 0; output counters (ox, oy) = 0; inflight = 0. Reset mid-frame aborts immediately; no DONE is produced.
- States and transitions:
  - IDLE: START=1 goes to RUN and clears ix, iy, ox, oy and ERR. FILT_WREN is ignored in IDLE.
  - RUN: issues pixels. An issue at (WIDTH-1,HEIGHT-1) goes to DRAIN.
  - DRAIN: waits until inflight_next==0, then goes to DONE. inflight_next = inflight + issue - FILT_WREN.
  - DONE: DONE=1 for exactly one cycle, then IDLE. START in the DONE cycle is ignored.
- READY = (state==RUN) & SRC_VALID & ~SINK_AFULL. READY is combinational, with no bubble between consecutive issues.
- POSX/POSY are registered copies of ix/iy and are valid whenever state==RUN. On each issue:
  - ix increments.
  - When ix==WIDTH-1, ix wraps to 0 and iy increments.
  - The counters hold when READY=0.
- The filter latency is not a parameter. Completion is determined by inflight, an 8-bit counter:
  - +1 per issue, -1 per FILT_WREN; a simultaneous issue and FILT_WREN leaves it unchanged.
  - FILT_WREN while inflight==0 in RUN/DRAIN sets ERR; inflight stays 0.
  - An issue while inflight==255 sets ERR; the counter saturates.
- Output tagging:
  - OUT_SOF, OUT_EOL and OUT_EOF are combinational from FILT_WREN and ox/oy, so they align with the filter's registered output data.
  - ox/oy advance on FILT_WREN with the same wrap rule as ix/iy.
  - OUT_EOF coincides with OUT_EOL.
- Degenerate sizes: WIDTH=1 makes every output pixel EOL. WIDTH=HEIGHT=1 issues one pixel; SOF, EOL and EOF all assert on the single FILT_WREN.
- BUSY = (state==RUN)|(state==DRAIN), registered with the state.

Test Plan:
- WIDTH=4, HEIGHT=2, 1-cycle filter model, SRC_VALID=1, SINK_AFULL=0, START pulse:
  - READY is high 8 consecutive cycles.
  - POSX/POSY sequence (0,0)(1,0)(2,0)(3,0)(0,1)..(3,1).
  - OUT_EOL on output 4 and output 8; OUT_EOF on output 8.
  - DONE pulses exactly once, 1 cycle after DRAIN sees inflight_next=0; BUSY drops in the same cycle.
- Same frame with SRC_VALID low every other cycle and SINK_AFULL high for 3 cycles mid-line:
  - READY is never high while either condition blocks.
  - POSX does not skip or repeat.
  - 8 outputs and 1 DONE.
- 4-cycle filter model: DRAIN lasts until the 8th FILT_WREN, then DONE. inflight peaks at 4.
- START held high throughout and re-asserted during RUN: exactly one frame per IDLE entry, with no restart mid-frame.
- RST=0 for one cycle after 5 issues:
  - Next cycle BUSY=0, POSX=POSY=0, no DONE.
  - Later stray FILT_WREN in IDLE leaves ERR=0.
  - A new START runs a clean full frame.
- Error injection: FILT_WREN with nothing issued in RUN sets ERR=1, which stays until the next START; START clears ERR to 0.
- Degenerate size: WIDTH=HEIGHT=1 gives 1 issue at (0,0), and OUT_SOF=OUT_EOL=OUT_EOF=1 on the single FILT_WREN.
